// File: rtl/hsid_element_feeder.sv
// hsid_element_feeder: streams pixel/library word pairs to the MSE datapath, one word per cycle per library vector.
// Optional build macro HSID_ELEMENT_FEEDER_ODD_MASK_EN zeroes the unused upper element of the last word when hsi_bands is odd.
package hsid_pkg;
  localparam int HSID_DATA_WIDTH        = 16;
  localparam int HSID_WORD_WIDTH        = 32;
  localparam int HSID_HSP_BANDS_WIDTH   = 8;
  localparam int HSID_HSP_LIBRARY_WIDTH = 6;
endpackage

module hsid_element_feeder
  import hsid_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int DATA_WIDTH        = HSID_DATA_WIDTH,
  parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       clear,
  input  logic                                       start,
  input  logic [HSP_BANDS_WIDTH-1:0]                 hsi_bands,
  input  logic [HSP_LIBRARY_WIDTH-1:0]               library_size,
  output logic                                       pixel_rd_en,
  output logic [HSP_BANDS_WIDTH-1:0]                 pixel_rd_addr,
  input  logic [WORD_WIDTH-1:0]                      pixel_rd_data,
  output logic                                       lib_rd_en,
  output logic [HSP_BANDS_WIDTH+HSP_LIBRARY_WIDTH-1:0] lib_rd_addr,
  input  logic [WORD_WIDTH-1:0]                      lib_rd_data,
  output logic [WORD_WIDTH-1:0]                      element_a,
  output logic [WORD_WIDTH-1:0]                      element_b,
  output logic                                       element_valid,
  output logic                                       element_start,
  output logic                                       element_last,
  output logic [HSP_LIBRARY_WIDTH-1:0]               vctr_ref,
  output logic                                       busy,
  output logic                                       done
);
  localparam int BW = HSP_BANDS_WIDTH;
  localparam int LW = HSP_LIBRARY_WIDTH;
  localparam logic [BW:0]      B1X = 1;
  localparam logic [BW-1:0]    B1  = 1;
  localparam logic [LW-1:0]    L1  = 1;
  localparam logic [BW+LW-1:0] A1  = 1;
  localparam logic [WORD_WIDTH-1:0] LO_MASK = {{(WORD_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state_q;
  logic              rd_q, done_q;
  logic [BW-1:0]     words_q, pix_q;
  logic [LW-1:0]     size_q, vec_q;
  logic [BW+LW-1:0]  lib_q;
  logic              p_vld_q, p_start_q, p_last_q, p_fin_q;
  logic [LW-1:0]     p_ref_q;
  logic              e_vld_q, e_start_q, e_last_q, e_fin_q;
  logic [LW-1:0]     e_ref_q;
  logic [WORD_WIDTH-1:0] e_a_q, e_b_q;
`ifdef HSID_ELEMENT_FEEDER_ODD_MASK_EN
  logic              odd_q;
`endif

  logic [BW:0]           bands_inc;
  logic [BW-1:0]         words_d;
  logic                  rd_last, rd_fin, empty, msk;
  logic [WORD_WIDTH-1:0] a_d, b_d;

  always_comb begin
    // widen before the +1 so the maximum band count does not wrap
    bands_inc = {1'b0, hsi_bands} + B1X;
    words_d   = bands_inc[BW:1];
    empty     = (hsi_bands == '0) || (library_size == '0);
    rd_last   = pix_q == (words_q - B1);
    rd_fin    = rd_last && (vec_q == (size_q - L1));
`ifdef HSID_ELEMENT_FEEDER_ODD_MASK_EN
    msk       = odd_q && p_last_q;
`else
    msk       = 1'b0;
`endif
    a_d       = msk ? (pixel_rd_data & LO_MASK) : pixel_rd_data;
    b_d       = msk ? (lib_rd_data & LO_MASK) : lib_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      words_q <= '0;
      size_q  <= '0;
      pix_q   <= '0;
      vec_q   <= '0;
      lib_q   <= '0;
`ifdef HSID_ELEMENT_FEEDER_ODD_MASK_EN
      odd_q   <= 1'b0;
`endif
    end else if (clear) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      pix_q   <= '0;
      vec_q   <= '0;
      lib_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= start && empty;
          if (start && !empty) begin
            state_q <= READ;
            rd_q    <= 1'b1;
            words_q <= words_d;
            size_q  <= library_size;
            pix_q   <= '0;
            vec_q   <= '0;
            lib_q   <= '0;
`ifdef HSID_ELEMENT_FEEDER_ODD_MASK_EN
            odd_q   <= hsi_bands[0];
`endif
          end
        end
        READ: begin
          pix_q <= rd_last ? '0 : pix_q + B1;
          vec_q <= rd_last ? vec_q + L1 : vec_q;
          lib_q <= lib_q + A1;
          if (rd_fin) begin
            state_q <= DRAIN;
            rd_q    <= 1'b0;
          end
        end
        DRAIN: begin
          if (e_fin_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // p_* tracks the read issued last cycle, aligned with the returning memory data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld_q   <= 1'b0;
      p_start_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_fin_q   <= 1'b0;
      p_ref_q   <= '0;
      e_vld_q   <= 1'b0;
      e_start_q <= 1'b0;
      e_last_q  <= 1'b0;
      e_fin_q   <= 1'b0;
      e_ref_q   <= '0;
      e_a_q     <= '0;
      e_b_q     <= '0;
    end else if (clear) begin
      p_vld_q   <= 1'b0;
      p_start_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_fin_q   <= 1'b0;
      e_vld_q   <= 1'b0;
      e_start_q <= 1'b0;
      e_last_q  <= 1'b0;
      e_fin_q   <= 1'b0;
    end else begin
      p_vld_q   <= rd_q;
      p_start_q <= rd_q && (pix_q == '0);
      p_last_q  <= rd_q && rd_last;
      p_fin_q   <= rd_q && rd_fin;
      p_ref_q   <= vec_q;
      e_vld_q   <= p_vld_q;
      e_start_q <= p_start_q;
      e_last_q  <= p_last_q;
      e_fin_q   <= p_fin_q;
      if (p_vld_q) begin
        e_a_q   <= a_d;
        e_b_q   <= b_d;
        e_ref_q <= p_ref_q;
      end
    end
  end

  assign pixel_rd_en   = rd_q;
  assign lib_rd_en     = rd_q;
  assign pixel_rd_addr = pix_q;
  assign lib_rd_addr   = lib_q;
  assign element_a     = e_a_q;
  assign element_b     = e_b_q;
  assign element_valid = e_vld_q;
  assign element_start = e_start_q;
  assign element_last  = e_last_q;
  assign vctr_ref      = e_ref_q;
  assign busy          = state_q != IDLE;
  assign done          = done_q;
endmodule

// File: tb/tb_hsid_element_feeder.sv
// tb_hsid_element_feeder: scoreboard bench; stimulus queues expected beats, a negedge monitor pops and compares.
module tb_hsid_element_feeder;
  localparam int WW = 32;
  localparam int BW = 8;
  localparam int LW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic start = 1'b0;
  logic [BW-1:0] hsi_bands = '0;
  logic [LW-1:0] library_size = '0;
  logic pixel_rd_en, lib_rd_en;
  logic [BW-1:0] pixel_rd_addr;
  logic [BW+LW-1:0] lib_rd_addr;
  logic [WW-1:0] pixel_rd_data = '0;
  logic [WW-1:0] lib_rd_data = '0;
  logic [WW-1:0] element_a, element_b;
  logic element_valid, element_start, element_last, busy, done;
  logic [LW-1:0] vctr_ref;

  hsid_element_feeder dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
    .hsi_bands(hsi_bands), .library_size(library_size),
    .pixel_rd_en(pixel_rd_en), .pixel_rd_addr(pixel_rd_addr), .pixel_rd_data(pixel_rd_data),
    .lib_rd_en(lib_rd_en), .lib_rd_addr(lib_rd_addr), .lib_rd_data(lib_rd_data),
    .element_a(element_a), .element_b(element_b),
    .element_valid(element_valid), .element_start(element_start), .element_last(element_last),
    .vctr_ref(vctr_ref), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // memories tag each word with its address so address sequencing shows up in the data
  always @(posedge clk) begin
    if (pixel_rd_en) pixel_rd_data <= {16'hAAAA, 8'h10, pixel_rd_addr};
    if (lib_rd_en) lib_rd_data <= {16'hAAAA, 2'b00, lib_rd_addr};
  end

  typedef struct packed {
    logic [WW-1:0] a;
    logic [WW-1:0] b;
    logic          s;
    logic          l;
    logic [LW-1:0] v;
  } beat_t;

  beat_t sb[$];
  beat_t e;
  int errors = 0;
  int checks = 0;
  int beats = 0;
  int rds = 0;
  int rds0, beats0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic s, input logic l, input logic [LW-1:0] v);
    sb.push_back({a, b, s, l, v});
  endtask

  always @(negedge clk) begin
    if (pixel_rd_en) rds++;
    if (element_valid) begin
      beats++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got beat vctr_ref=%0d a=%0h expected no beat", vctr_ref, element_a);
      end else begin
        e = sb.pop_front();
        chk("element_a", 64'(element_a), 64'(e.a));
        chk("element_b", 64'(element_b), 64'(e.b));
        chk("element_start", 64'(element_start), 64'(e.s));
        chk("element_last", 64'(element_last), 64'(e.l));
        chk("vctr_ref", 64'(vctr_ref), 64'(e.v));
      end
    end else begin
      chk("idle_qualifiers", 64'({element_start, element_last}), 64'(0));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [BW-1:0] b, input logic [LW-1:0] l);
    hsi_bands = b;
    library_size = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // c0 is the cycle offset from the start cycle at entry
  task automatic wait_done(input int c0, input int exp, input string name);
    int c;
    c = c0;
    while (!done && c < 200) begin
      step();
      c++;
    end
    chk(name, 64'(c), 64'(exp));
    chk({name, "_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic mark;
    rds0 = rds;
    beats0 = beats;
  endtask

  initial begin
    step();
    step();
    chk("rst_outputs", 64'({pixel_rd_en, lib_rd_en, element_valid, busy, done}), 64'(0));
    chk("rst_addr", 64'({pixel_rd_addr, lib_rd_addr}), 64'(0));
    chk("rst_elem", 64'({element_a, vctr_ref}), 64'(0));
    rst_n = 1'b1;
    step();

    // bands=4 lib=2: W=2
    mark();
    push(32'hAAAA1000, 32'hAAAA0000, 1, 0, 0);
    push(32'hAAAA1001, 32'hAAAA0001, 0, 1, 0);
    push(32'hAAAA1000, 32'hAAAA0002, 1, 0, 1);
    push(32'hAAAA1001, 32'hAAAA0003, 0, 1, 1);
    launch(4, 2);
    chk("t1_first_rd", 64'({pixel_rd_en, lib_rd_en, busy}), 64'(3'b111));
    wait_done(1, 7, "t1_done");
    chk("t1_rds", 64'(rds - rds0), 64'(4));
    chk("t1_sb_empty", 64'(sb.size()), 64'(0));
    step();
    chk("t1_done_pulse", 64'(done), 64'(0));

    // bands=5 lib=1: W=3, last word carries one element
    mark();
    push(32'hAAAA1000, 32'hAAAA0000, 1, 0, 0);
    push(32'hAAAA1001, 32'hAAAA0001, 0, 0, 0);
`ifdef HSID_ELEMENT_FEEDER_ODD_MASK_EN
    push(32'h00001002, 32'h00000002, 0, 1, 0);
`else
    push(32'hAAAA1002, 32'hAAAA0002, 0, 1, 0);
`endif
    launch(5, 1);
    wait_done(1, 6, "t2_done");
    chk("t2_beats", 64'(beats - beats0), 64'(3));

    // bands=1 lib=3: W=1, every beat is both start and last
    mark();
    push(32'hAAAA1000, 32'hAAAA0000, 1, 1, 0);
    push(32'hAAAA1000, 32'hAAAA0001, 1, 1, 1);
    push(32'hAAAA1000, 32'hAAAA0002, 1, 1, 2);
    launch(1, 3);
    wait_done(1, 6, "t3_done");
    chk("t3_beats", 64'(beats - beats0), 64'(3));

    // empty library
    mark();
    launch(4, 0);
    chk("t4_done", 64'({done, busy, pixel_rd_en}), 64'(3'b100));
    step();
    chk("t4_done_pulse", 64'({done, busy}), 64'(0));
    repeat (4) step();
    chk("t4_no_activity", 64'((rds - rds0) + (beats - beats0)), 64'(0));

    // clear at third beat of bands=8 lib=4
    mark();
    push(32'hAAAA1000, 32'hAAAA0000, 1, 0, 0);
    push(32'hAAAA1001, 32'hAAAA0001, 0, 0, 0);
    push(32'hAAAA1002, 32'hAAAA0002, 0, 0, 0);
    launch(8, 4);
    repeat (4) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t5_clear", 64'({element_valid, busy, pixel_rd_en, lib_rd_en, done}), 64'(0));
    begin
      int dn;
      dn = 0;
      repeat (10) begin
        step();
        dn += int'(done);
      end
      chk("t5_no_done", 64'(dn), 64'(0));
    end
    chk("t5_beats", 64'(beats - beats0), 64'(3));
    mark();
    for (int v = 0; v < 4; v++)
      for (int w = 0; w < 4; w++)
        push(32'hAAAA1000 | WW'(w), 32'hAAAA0000 | WW'(v * 4 + w), w == 0, w == 3, LW'(v));
    launch(8, 4);
    wait_done(1, 19, "t5_rerun_done");
    chk("t5_rerun_beats", 64'(beats - beats0), 64'(16));

    // start while busy is ignored
    mark();
    push(32'hAAAA1000, 32'hAAAA0000, 1, 0, 0);
    push(32'hAAAA1001, 32'hAAAA0001, 0, 1, 0);
    push(32'hAAAA1000, 32'hAAAA0002, 1, 0, 1);
    push(32'hAAAA1001, 32'hAAAA0003, 0, 1, 1);
    launch(4, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(2, 7, "t6_done");
    repeat (6) step();
    chk("t6_beats", 64'(beats - beats0), 64'(4));

    // asynchronous reset mid-pass
    mark();
    launch(8, 4);
    step();
    rst_n = 1'b0;
    #1;
    chk("t7_rst_strobes", 64'({pixel_rd_en, lib_rd_en, element_valid, busy, done}), 64'(0));
    chk("t7_rst_addr", 64'({pixel_rd_addr, lib_rd_addr}), 64'(0));
    repeat (3) step();
    rst_n = 1'b1;
    begin
      int dn;
      dn = 0;
      repeat (25) begin
        step();
        dn += int'(done);
      end
      chk("t7_no_done", 64'(dn), 64'(0));
    end
    chk("t7_no_beats", 64'(beats - beats0), 64'(0));
    chk("final_sb_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
